// File: rtl/stepper_motor_control_cpu_div_cell_if.sv
// Divider request/response bundle between the M-stage control (master) and the divide cell (slave).
// Handshake: M_div_start is accepted only while M_div_busy=0; operands are sampled on that edge;
// M_div_done pulses for one cycle when M_div_quotient/M_div_remainder become valid.
interface stepper_motor_control_cpu_div_cell_if;
  logic [31:0] M_div_src1;
  logic [31:0] M_div_src2;
  logic        M_div_signed;
  logic        M_div_start;
  logic        M_div_busy;
  logic        M_div_done;
  logic [31:0] M_div_quotient;
  logic [31:0] M_div_remainder;

  modport master (
    output M_div_src1, M_div_src2, M_div_signed, M_div_start,
    input  M_div_busy, M_div_done, M_div_quotient, M_div_remainder
  );

  modport slave (
    input  M_div_src1, M_div_src2, M_div_signed, M_div_start,
    output M_div_busy, M_div_done, M_div_quotient, M_div_remainder
  );
endinterface

// File: rtl/stepper_motor_control_cpu_div_cell.sv
// Iterative 32-bit radix-2 restoring divider, one quotient bit per clock, fixed 34-cycle latency.
// Optional macro CPU_DIV_SIGNED_EN compiles in two's-complement abs/negate handling.
module stepper_motor_control_cpu_div_cell (
  input  logic                                 clk,
  input  logic                                 reset,
  stepper_motor_control_cpu_div_cell_if.slave  div_if,
  output logic [1:0]                           dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;
  logic [31:0] quot_out_q, quot_out_d;
  logic [31:0] rem_out_q, rem_out_d;

  logic [31:0] a_mag, b_mag;
  logic        a_neg, b_neg;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] q_fin, r_fin;

  // Operand magnitudes and result signs; unsigned build treats everything as non-negative.
`ifdef CPU_DIV_SIGNED_EN
  assign a_neg = div_if.M_div_signed & div_if.M_div_src1[31];
  assign b_neg = div_if.M_div_signed & div_if.M_div_src2[31];
`else
  logic unused_signed;
  assign unused_signed = div_if.M_div_signed;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  assign a_mag = a_neg ? (~div_if.M_div_src1 + 32'd1) : div_if.M_div_src1;
  assign b_mag = b_neg ? (~div_if.M_div_src2 + 32'd1) : div_if.M_div_src2;

  assign shifted = {rem_q[31:0], quo_q[31]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_q};

  // Divide-by-zero: the magnitude path already leaves |src1| in the remainder, so re-applying the
  // dividend sign restores the original src1; only the quotient needs overriding.
  assign q_fin = dz_q ? 32'hFFFF_FFFF : (qsign_q ? (~quo_q + 32'd1) : quo_q);
  assign r_fin = rsign_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    qsign_d    = qsign_q;
    rsign_d    = rsign_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    case (state_q)
      S_IDLE: begin
        if (div_if.M_div_start) begin
          quo_d   = a_mag;
          dvs_d   = b_mag;
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          dz_d    = (div_if.M_div_src2 == 32'd0);
          rem_d   = 33'd0;
          cnt_d   = 6'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!diff[33]) begin
          rem_d = diff[32:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_FIX;
      end
      S_FIX: begin
        quot_out_d = q_fin;
        rem_out_d  = r_fin;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      rem_q      <= 33'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
      qsign_q    <= 1'b0;
      rsign_q    <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      quot_out_q <= 32'd0;
      rem_out_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      qsign_q    <= qsign_d;
      rsign_q    <= rsign_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
    end
  end

  assign div_if.M_div_busy      = (state_q != S_IDLE);
  assign div_if.M_div_done      = done_q;
  assign div_if.M_div_quotient  = quot_out_q;
  assign div_if.M_div_remainder = rem_out_q;
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_stepper_motor_control_cpu_div_cell.sv
// Self-checking bench for the iterative divide cell: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_stepper_motor_control_cpu_div_cell;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  stepper_motor_control_cpu_div_cell_if dif ();

  stepper_motor_control_cpu_div_cell dut (
    .clk         (clk),
    .reset       (reset),
    .div_if      (dif.slave),
    .dbg_state_o (dbg_state)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_q = 32'd0;
  logic [31:0] last_r = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic; SV '/' truncates toward zero and '%' follows the dividend.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    logic   use_signed;
    use_signed = 1'b0;
`ifdef CPU_DIV_SIGNED_EN
    use_signed = s;
`endif
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (use_signed) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  // Call at a negedge; returns #1 after the accepting posedge with start released.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    dif.M_div_src1   = a;
    dif.M_div_src2   = b;
    dif.M_div_signed = s;
    dif.M_div_start  = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    check("busy_after_start", 64'(dif.M_div_busy), 64'd1);
    dif.M_div_start  = 1'b0;
    dif.M_div_src1   = $urandom;
    dif.M_div_src2   = $urandom;
    dif.M_div_signed = 1'($urandom_range(0, 1));
  endtask

  // Waits for done (ends on the negedge of the done cycle); optionally strobes a stray start.
  task automatic wait_done(input int inject_n);
    int          n;
    int          busy_cycles;
    logic [63:0] e;
    n = 0;
    busy_cycles = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == inject_n + 1) dif.M_div_start = 1'b0;
      if (dif.M_div_done) break;
      if (dif.M_div_busy) busy_cycles++;
      if (n == 10) check("hold_outputs", {dif.M_div_quotient, dif.M_div_remainder}, {last_q, last_r});
      if (n == inject_n) begin
        dif.M_div_start = 1'b1;
        dif.M_div_src1  = $urandom;
        dif.M_div_src2  = $urandom_range(1, 255);
      end
      if (n >= 40) begin
        check("done_timeout", 64'(n), 64'd34);
        break;
      end
    end
    check("latency", 64'(n), 64'd34);
    check("busy_cycles", 64'(busy_cycles), 64'd33);
    check("busy_in_done", 64'(dif.M_div_busy), 64'd0);
    e = exp_q.pop_front();
    check("result", {dif.M_div_quotient, dif.M_div_remainder}, e);
    last_q = e[63:32];
    last_r = e[31:0];
  endtask

  task automatic done_drops;
    @(negedge clk);
    check("done_one_cycle", 64'(dif.M_div_done), 64'd0);
  endtask

  logic [31:0] dir_a[6] = '{32'd100, 32'hFFFF_FFF9, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [31:0] dir_b[6] = '{32'd7,   32'd2,         32'd0,         32'd0,         32'hFFFF_FFFF, 32'd1};
  logic        dir_s[6] = '{1'b0,    1'b1,          1'b1,          1'b0,          1'b1,          1'b0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done_seen;
    int gap;
    logic [31:0] a, b;
    reset            = 1'b1;
    dif.M_div_start  = 1'b0;
    dif.M_div_src1   = 32'd0;
    dif.M_div_src2   = 32'd0;
    dif.M_div_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy_done", {62'd0, dif.M_div_busy, dif.M_div_done}, 64'd0);
    check("reset_outputs", {dif.M_div_quotient, dif.M_div_remainder}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed corner cases; the first one also carries a stray start at T+5.
    for (int i = 0; i < 6; i++) begin
      drive_start(dir_a[i], dir_b[i], dir_s[i]);
      wait_done(i == 0 ? 5 : -1);
      done_drops();
    end

    // Start accepted in the done cycle.
    drive_start(32'd1000, 32'd3, 1'b0);
    wait_done(-1);
    drive_start(32'd50, 32'd5, 1'b0);
    wait_done(-1);
    done_drops();

    // Mid-operation reset aborts with no done pulse.
    drive_start($urandom, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy_done", {62'd0, dif.M_div_busy, dif.M_div_done}, 64'd0);
    check("abort_outputs", {dif.M_div_quotient, dif.M_div_remainder}, 64'd0);
    void'(exp_q.pop_back());
    last_q = 32'd0;
    last_r = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.M_div_done) done_seen++;
    end
    check("no_done_after_abort", 64'(done_seen), 64'd0);
    drive_start(32'd9, 32'd4, 1'b0);
    wait_done(-1);
    done_drops();

    // Random operands, random gaps (including back-to-back).
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 15);
        4:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        5:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      drive_start(a, b, 1'($urandom_range(0, 1)));
      wait_done(-1);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        done_drops();
        repeat (gap - 1) @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
